// File: rtl/score_capture.sv
// score_capture: receiving end of the multiplexed four-digit seven-segment bus.
// Registers the active-low anode/segment lines, decodes each digit to BCD,
// assembles mm:ss frames and reports them as elapsed seconds, together with
// frame valid/error pulses and a stability flag.
module score_capture #(
  parameter int STABLE_FRAMES = 2
) (
  input  logic        segclk,
  input  logic        rst_n,
  input  logic [3:0]  anode,
  input  logic [6:0]  segment,
  output logic [15:0] timealive,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        stable
);

  typedef enum logic {COLLECT, CHECK} state_t;

  // Returns {pattern_ok, bcd_digit} for an active-low a..g segment pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: seg_decode = {1'b1, 4'd0};
      7'b1001111: seg_decode = {1'b1, 4'd1};
      7'b0010010: seg_decode = {1'b1, 4'd2};
      7'b0000110: seg_decode = {1'b1, 4'd3};
      7'b1001100: seg_decode = {1'b1, 4'd4};
      7'b0100100: seg_decode = {1'b1, 4'd5};
      7'b0100000: seg_decode = {1'b1, 4'd6};
      7'b0001111: seg_decode = {1'b1, 4'd7};
      7'b0000000: seg_decode = {1'b1, 4'd8};
      7'b0000100: seg_decode = {1'b1, 4'd9};
      default:    seg_decode = {1'b0, 4'd0};
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  anode_q;
  logic [6:0]  segment_q;
  logic [3:0]  mask_q, mask_d;
  logic        err_q, err_d;
  logic [3:0]  m10_q, m10_d, m1_q, m1_d, s10_q, s10_d, s1_q, s1_d;
  logic [15:0] time_q, time_d;
  logic        fv_q, fv_d, fe_q, fe_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [4:0]  dec;
  logic        an_legal, an_blank, new_err;
  logic [3:0]  cap_bits;
  logic [12:0] mins_w, secs_w, total_w;

  // Decode the S-stage registers: which slot (if any) is captured and whether it is bad.
  always_comb begin
    dec      = seg_decode(segment_q);
    an_blank = (anode_q == 4'b1111);
    an_legal = (anode_q == 4'b0111) || (anode_q == 4'b1011) ||
               (anode_q == 4'b1101) || (anode_q == 4'b1110);
    cap_bits = an_legal ? ~anode_q : 4'b0000;
    new_err  = (!an_legal && !an_blank) || (an_legal && !dec[4]);
  end

  // Write a correctly decoded digit into its slot; the latest capture wins.
  always_comb begin
    m10_d = m10_q;
    m1_d  = m1_q;
    s10_d = s10_q;
    s1_d  = s1_q;
    if (dec[4]) begin
      case (anode_q)
        4'b0111: m10_d = dec[3:0];
        4'b1011: m1_d  = dec[3:0];
        4'b1101: s10_d = dec[3:0];
        4'b1110: s1_d  = dec[3:0];
        default: ;
      endcase
    end
  end

  // Elapsed seconds of the frame held in the slot registers (max 5999 fits 13 bits).
  always_comb begin
    mins_w  = 13'(m10_q) * 13'd10 + 13'(m1_q);
    secs_w  = 13'(s10_q) * 13'd10 + 13'(s1_q);
    total_w = mins_w * 13'd60 + secs_w;
  end

  // Frame FSM: collect the mask, then judge the frame and update stability.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q | cap_bits;
    err_d   = err_q | new_err;
    time_d  = time_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      COLLECT: begin
        if (mask_d == 4'b1111) state_d = CHECK;
      end
      CHECK: begin
        state_d = COLLECT;
        // A digit arriving now belongs to the next frame.
        mask_d  = cap_bits;
        err_d   = new_err;
        if (err_q || (s10_q > 4'd5)) begin
          fe_d  = 1'b1;
          cnt_d = 4'd0;
        end else begin
          fv_d   = 1'b1;
          time_d = {3'b000, total_w};
          if ({3'b000, total_w} == time_q) begin
            if (cnt_q < 4'(STABLE_FRAMES)) cnt_d = cnt_q + 4'd1;
          end else begin
            cnt_d = 4'd1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State and datapath registers; the input stage resets to the blank code.
  always_ff @(posedge segclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      anode_q   <= 4'b1111;
      segment_q <= 7'b1111111;
      mask_q    <= 4'b0000;
      err_q     <= 1'b0;
      m10_q     <= 4'd0;
      m1_q      <= 4'd0;
      s10_q     <= 4'd0;
      s1_q      <= 4'd0;
      time_q    <= 16'd0;
      fv_q      <= 1'b0;
      fe_q      <= 1'b0;
      cnt_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      anode_q   <= anode;
      segment_q <= segment;
      mask_q    <= mask_d;
      err_q     <= err_d;
      m10_q     <= m10_d;
      m1_q      <= m1_d;
      s10_q     <= s10_d;
      s1_q      <= s1_d;
      time_q    <= time_d;
      fv_q      <= fv_d;
      fe_q      <= fe_d;
      cnt_q     <= cnt_d;
    end
  end

  assign timealive   = time_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign stable      = (cnt_q >= 4'(STABLE_FRAMES));

endmodule

// File: tb/tb_score_capture.sv
// Directed bench for score_capture: a vector table with per-cycle expected
// outputs plus a hand-written reset-abort sequence.
module tb_score_capture;

  logic        segclk = 1'b0;
  logic        rst_n;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic [15:0] timealive;
  logic        frame_valid, frame_err, stable;

  int nchecks = 0;
  int nerrors = 0;

  score_capture #(.STABLE_FRAMES(2)) dut (
    .segclk      (segclk),
    .rst_n       (rst_n),
    .anode       (anode),
    .segment     (segment),
    .timealive   (timealive),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .stable      (stable)
  );

  always #5 segclk = ~segclk;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  sg;
    logic        fv;
    logic        fe;
    logic [15:0] ta;
    logic        st;
  } vec_t;

  typedef struct {
    int          row;
    logic        fv;
    logic        fe;
    logic [15:0] ta;
    logic        st;
  } ev_t;

  vec_t vecs[$];
  ev_t  evs[$];

  localparam logic [3:0] AM10 = 4'b0111, AM1 = 4'b1011, AS10 = 4'b1101, AS1 = 4'b1110;
  localparam logic [3:0] ABLK = 4'b1111;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b0000001;
      1: seg_of = 7'b1001111;
      2: seg_of = 7'b0010010;
      3: seg_of = 7'b0000110;
      4: seg_of = 7'b1001100;
      5: seg_of = 7'b0100100;
      6: seg_of = 7'b0100000;
      7: seg_of = 7'b0001111;
      8: seg_of = 7'b0000000;
      9: seg_of = 7'b0000100;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] an, input logic [6:0] sg);
    vec_t v;
    v.an = an; v.sg = sg; v.fv = 1'b0; v.fe = 1'b0; v.ta = 16'd0; v.st = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic scan(input int m10, input int m1, input int s10, input int s1);
    push(AM10, seg_of(m10));
    push(AM1,  seg_of(m1));
    push(AS10, seg_of(s10));
    push(AS1,  seg_of(s1));
  endtask

  task automatic add_ev(input int row, input logic fv, input logic fe,
                        input logic [15:0] ta, input logic st);
    ev_t e;
    e.row = row; e.fv = fv; e.fe = fe; e.ta = ta; e.st = st;
    evs.push_back(e);
  endtask

  task automatic drive_cycle(input logic [3:0] an, input logic [6:0] sg);
    @(negedge segclk);
    anode   = an;
    segment = sg;
    @(posedge segclk);
    #1;
  endtask

  initial begin
    logic [15:0] cur_ta;
    logic        cur_st;
    int          ei;

    rst_n   = 1'b0;
    anode   = ABLK;
    segment = 7'b1111111;

    // ---------------- Stimulus table ----------------
    scan(1, 2, 3, 4);                     // rows 0-3
    scan(1, 2, 3, 4);                     // rows 4-7
    scan(9, 9, 5, 9);                     // rows 8-11
    scan(9, 9, 5, 9);                     // rows 12-15
    scan(0, 0, 0, 0);                     // rows 16-19
    scan(0, 0, 0, 0);                     // rows 20-23
    push(AM10, seg_of(1));                // rows 24-27: bad pattern on minutes ones
    push(AM1,  7'b1111111);
    push(AS10, seg_of(3));
    push(AS1,  seg_of(4));
    scan(1, 2, 3, 4);                     // rows 28-31
    scan(0, 0, 6, 5);                     // rows 32-35: seconds tens = 6
    scan(1, 2, 3, 4);                     // rows 36-39
    scan(1, 2, 3, 4);                     // rows 40-43
    push(AM10, seg_of(1));                // row 44
    push(4'b0011, seg_of(8));             // row 45: illegal anode
    push(AM1,  seg_of(2));                // row 46
    push(AS10, seg_of(3));                // row 47
    push(AS1,  seg_of(4));                // row 48
    push(ABLK, 7'b1111111);               // rows 49-51
    push(ABLK, 7'b1111111);
    push(ABLK, 7'b1111111);
    push(AS1,  seg_of(4));                // row 52: out of order with blanks
    push(ABLK, 7'b1111111);
    push(AM10, seg_of(1));                // row 54
    push(ABLK, 7'b1111111);
    push(AS10, seg_of(3));                // row 56
    push(ABLK, 7'b1111111);
    push(AM1,  seg_of(2));                // row 58: last digit
    push(ABLK, 7'b1111111);
    push(ABLK, 7'b1111111);               // row 60: report
    push(ABLK, 7'b1111111);

    // Hand-computed report cycles (last digit at row r -> outputs after row r+2).
    add_ev( 5, 1'b1, 1'b0, 16'd754,  1'b0);
    add_ev( 9, 1'b1, 1'b0, 16'd754,  1'b1);
    add_ev(13, 1'b1, 1'b0, 16'd5999, 1'b0);
    add_ev(17, 1'b1, 1'b0, 16'd5999, 1'b1);
    add_ev(21, 1'b1, 1'b0, 16'd0,    1'b0);
    add_ev(25, 1'b1, 1'b0, 16'd0,    1'b1);
    add_ev(29, 1'b0, 1'b1, 16'd0,    1'b0);
    add_ev(33, 1'b1, 1'b0, 16'd754,  1'b0);
    add_ev(37, 1'b0, 1'b1, 16'd754,  1'b0);
    add_ev(41, 1'b1, 1'b0, 16'd754,  1'b0);
    add_ev(45, 1'b1, 1'b0, 16'd754,  1'b1);
    add_ev(50, 1'b0, 1'b1, 16'd754,  1'b0);
    add_ev(60, 1'b1, 1'b0, 16'd754,  1'b0);

    // Outputs hold between report cycles.
    cur_ta = 16'd0;
    cur_st = 1'b0;
    ei     = 0;
    for (int r = 0; r < vecs.size(); r++) begin
      if (ei < evs.size() && evs[ei].row == r) begin
        vecs[r].fv = evs[ei].fv;
        vecs[r].fe = evs[ei].fe;
        cur_ta     = evs[ei].ta;
        cur_st     = evs[ei].st;
        ei++;
      end
      vecs[r].ta = cur_ta;
      vecs[r].st = cur_st;
    end

    // ---------------- Reset state ----------------
    repeat (3) @(posedge segclk);
    @(negedge segclk);
    rst_n = 1'b1;
    #1;
    check("reset timealive", timealive, 16'd0);
    check("reset frame_valid", {15'd0, frame_valid}, 16'd0);
    check("reset frame_err", {15'd0, frame_err}, 16'd0);
    check("reset stable", {15'd0, stable}, 16'd0);

    // ---------------- Table ----------------
    for (int r = 0; r < vecs.size(); r++) begin
      drive_cycle(vecs[r].an, vecs[r].sg);
      check($sformatf("row%0d frame_valid", r), {15'd0, frame_valid}, {15'd0, vecs[r].fv});
      check($sformatf("row%0d frame_err", r),   {15'd0, frame_err},   {15'd0, vecs[r].fe});
      check($sformatf("row%0d timealive", r),   timealive,            vecs[r].ta);
      check($sformatf("row%0d stable", r),      {15'd0, stable},      {15'd0, vecs[r].st});
    end

    // ---------------- Reset mid-frame ----------------
    drive_cycle(AM10, seg_of(1));
    drive_cycle(AM1,  seg_of(2));
    @(negedge segclk);
    anode   = ABLK;
    segment = 7'b1111111;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort timealive", timealive, 16'd0);
    check("abort frame_valid", {15'd0, frame_valid}, 16'd0);
    check("abort frame_err", {15'd0, frame_err}, 16'd0);
    check("abort stable", {15'd0, stable}, 16'd0);
    @(negedge segclk);
    rst_n = 1'b1;

    // Only the seconds digits: the aborted minutes must not complete a frame.
    drive_cycle(AS10, seg_of(0));
    drive_cycle(AS1,  seg_of(7));
    for (int i = 0; i < 4; i++) begin
      drive_cycle(ABLK, 7'b1111111);
      check($sformatf("post-reset idle%0d frame_valid", i), {15'd0, frame_valid}, 16'd0);
      check($sformatf("post-reset idle%0d frame_err", i), {15'd0, frame_err}, 16'd0);
      check($sformatf("post-reset idle%0d timealive", i), timealive, 16'd0);
    end
    drive_cycle(AM10, seg_of(0));
    drive_cycle(AM1,  seg_of(0));
    check("0007 E0 frame_valid", {15'd0, frame_valid}, 16'd0);
    drive_cycle(ABLK, 7'b1111111);
    check("0007 E1 frame_valid", {15'd0, frame_valid}, 16'd0);
    drive_cycle(ABLK, 7'b1111111);
    check("0007 E2 frame_valid", {15'd0, frame_valid}, 16'd1);
    check("0007 E2 frame_err", {15'd0, frame_err}, 16'd0);
    check("0007 E2 timealive", timealive, 16'd7);
    check("0007 E2 stable", {15'd0, stable}, 16'd0);
    drive_cycle(ABLK, 7'b1111111);
    check("0007 E3 frame_valid", {15'd0, frame_valid}, 16'd0);
    check("0007 E3 timealive", timealive, 16'd7);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
